// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a double-buffered ASCII frame.
// Each digit slot is a blanking gap followed by a lit window.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic                  commit,
    input  logic                  display_en,
    output logic [7:0]            ch,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  commit_pending,
    output logic                  frame_start
);

    typedef enum logic {
        ST_BLANK,
        ST_ON
    } state_t;

    localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYC - 1);
    localparam logic [31:0] ON_LAST    = 32'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [2:0]  DIGIT_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]  SPACE      = 8'h20;

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [2:0]              digit_q, digit_d;
    logic [7:0]              shadow_q [NUM_DIGITS];
    logic [7:0]              shadow_d [NUM_DIGITS];
    logic [7:0]              active_q [NUM_DIGITS];
    logic [7:0]              active_d [NUM_DIGITS];
    logic                    pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              ch_q, ch_d;
    logic                    boundary;
    logic                    do_copy;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 32'd1;
        digit_d  = digit_q;
        boundary = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (digit_q == DIGIT_LAST) begin
                        digit_d  = '0;
                        boundary = 1'b1;
                    end else begin
                        digit_d = digit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // A commit landing on the boundary still copies, and stays pending.
    always_comb begin
        do_copy = boundary && (pend_q || commit);
        pend_d  = boundary ? commit : (pend_q || commit);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (wr_en && (wr_addr == 3'(i))) begin
                shadow_d[i] = wr_data;
            end
            if (do_copy) begin
                active_d[i] = shadow_q[i];
            end
        end
    end

    always_comb begin
        an_d = '1;
        ch_d = SPACE;
        if ((state_q == ST_ON) && display_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_q == 3'(i)) begin
                    an_d[i] = 1'b0;
                    ch_d    = active_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            digit_q <= '0;
            pend_q  <= 1'b0;
            an_q    <= '1;
            ch_q    <= SPACE;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= SPACE;
                active_q[i] <= SPACE;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            pend_q  <= pend_d;
            an_q    <= an_d;
            ch_q    <= ch_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign ch             = ch_q;
    assign an             = an_q;
    assign commit_pending = pend_q;
    assign frame_start    = boundary;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 10-clock slots, 2-clock blank.
// Edges are counted from reset release; outputs are sampled on falling edges.
module tb_seg7_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic       display_en;
    logic [7:0] ch;
    logic [3:0] an;
    logic       commit_pending;
    logic       frame_start;

    int n_assert = 0;
    int n_fail   = 0;
    int ecount   = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS(4),
        .SCAN_DIV  (10),
        .BLANK_CYC (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .commit        (commit),
        .display_en    (display_en),
        .ch            (ch),
        .an            (an),
        .commit_pending(commit_pending),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h",
                   tag, ecount, obs, exp);
        end
    endtask

    task automatic adv();
        @(negedge clk);
        ecount++;
    endtask

    task automatic goto(input int t);
        while (ecount < t) adv();
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e,
                           input logic [7:0] ch_e);
        chk({tag, ".an"}, {28'd0, an}, {28'd0, an_e});
        chk({tag, ".ch"}, {24'd0, ch}, {24'd0, ch_e});
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = 3'd0;
        wr_data    = 8'h00;
        commit     = 1'b0;
        display_en = 1'b1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_out("rst", 4'b1111, 8'h20);
        chk("rst.pend", {31'd0, commit_pending}, 32'd0);
        chk("rst.fs", {31'd0, frame_start}, 32'd0);
        rst_n  = 1'b1;
        ecount = 0;

        goto(2);  chk_out("e2", 4'b1111, 8'h20);
        goto(3);  chk_out("e3", 4'b1110, 8'h20);
        goto(10); chk_out("e10", 4'b1110, 8'h20);
        goto(11); chk_out("e11", 4'b1111, 8'h20);
        goto(13); chk_out("e13", 4'b1101, 8'h20);
        goto(38); chk("fs38", {31'd0, frame_start}, 32'd0);
        goto(39); chk("fs39", {31'd0, frame_start}, 32'd1);
        goto(40); chk("fs40", {31'd0, frame_start}, 32'd0);
        goto(79); chk("fs79", {31'd0, frame_start}, 32'd1);
        goto(119); chk("fs119", {31'd0, frame_start}, 32'd1);

        goto(120);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h52; adv();
        wr_addr = 3'd1; wr_data = 8'h32; adv();
        wr_addr = 3'd2; wr_data = 8'h35; adv();
        wr_addr = 3'd3; wr_data = 8'h35; adv();
        wr_en = 1'b0; commit = 1'b1; adv();
        commit = 1'b0;
        chk("wc.pend", {31'd0, commit_pending}, 32'd1);
        goto(126); chk_out("wc.old", 4'b1110, 8'h20);
        goto(159);
        chk("wc.fs", {31'd0, frame_start}, 32'd1);
        chk("wc.pend159", {31'd0, commit_pending}, 32'd1);
        goto(160); chk("wc.pend160", {31'd0, commit_pending}, 32'd0);
        goto(165); chk_out("wc.d0", 4'b1110, 8'h52);
        goto(175); chk_out("wc.d1", 4'b1101, 8'h32);
        goto(185); chk_out("wc.d2", 4'b1011, 8'h35);
        goto(195); chk_out("wc.d3", 4'b0111, 8'h35);

        goto(196);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h47; adv();
        wr_en = 1'b0; commit = 1'b1; adv();
        commit = 1'b0;
        chk("oor.pend", {31'd0, commit_pending}, 32'd1);
        goto(200); chk("oor.pend200", {31'd0, commit_pending}, 32'd0);
        goto(205); chk_out("oor.d0", 4'b1110, 8'h52);
        goto(215); chk_out("oor.d1", 4'b1101, 8'h32);
        goto(225); chk_out("oor.d2", 4'b1011, 8'h35);
        goto(235); chk_out("oor.d3", 4'b0111, 8'h35);

        goto(239);
        chk("bc.fs", {31'd0, frame_start}, 32'd1);
        commit = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h42;
        adv();
        commit = 1'b0; wr_en = 1'b0;
        chk("bc.pend240", {31'd0, commit_pending}, 32'd1);
        goto(245); chk_out("bc.d0old", 4'b1110, 8'h52);
        goto(279); chk("bc.fs279", {31'd0, frame_start}, 32'd1);
        goto(280); chk("bc.pend280", {31'd0, commit_pending}, 32'd0);
        goto(285); chk_out("bc.d0new", 4'b1110, 8'h42);

        display_en = 1'b0;
        adv(); chk_out("dark", 4'b1111, 8'h20);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h58; adv();
        wr_en = 1'b0; commit = 1'b1; adv();
        commit = 1'b0;
        chk("dark.pend", {31'd0, commit_pending}, 32'd1);
        goto(319); chk("dark.fs", {31'd0, frame_start}, 32'd1);
        goto(320); chk("dark.pend320", {31'd0, commit_pending}, 32'd0);
        goto(354); chk_out("dark.d3", 4'b1111, 8'h20);
        display_en = 1'b1;
        adv(); chk_out("relit.d3", 4'b0111, 8'h58);

        goto(362);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h5A; adv();
        wr_en = 1'b0; commit = 1'b1; adv();
        commit = 1'b0;
        chk("mr.pend", {31'd0, commit_pending}, 32'd1);
        adv(); chk_out("mr.pre", 4'b1110, 8'h42);
        rst_n = 1'b0;
        adv();
        chk_out("mr.rst", 4'b1111, 8'h20);
        chk("mr.pend0", {31'd0, commit_pending}, 32'd0);
        chk("mr.fs0", {31'd0, frame_start}, 32'd0);
        rst_n  = 1'b1;
        ecount = 0;
        goto(5);  chk_out("mr.d0", 4'b1110, 8'h20);
        goto(15); chk_out("mr.d1", 4'b1101, 8'h20);
        goto(25); chk_out("mr.d2", 4'b1011, 8'h20);
        goto(35); chk_out("mr.d3", 4'b0111, 8'h20);
        goto(39); chk("mr.fs39", {31'd0, frame_start}, 32'd1);
        goto(45); chk_out("mr.f2d0", 4'b1110, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
